crc_stream: RTL and testbench
=============================

// Module: crc_stream
// PURPOSE
//  Parametrised CRC engine with a valid/ready byte-stream interface. Absorbs DATA_W bits
//  per accepted beat, one frame at a time, delimited by in_last. Presents final CRC plus
//  match flag against a caller-supplied expected value. Generalises the bit-serial CRC8
//  unit to any CRC width (1..32), any beat width, framing, back-pressure and check mode.
// PARAMETERS
//  CRC_W    8      CRC register width, 1..32
//  DATA_W   8      bits consumed per accepted beat, 1..64
//  POLY     8'h07  generator polynomial, implicit x^CRC_W term omitted, [CRC_W-1:0]
//  INIT     8'h00  register value at frame start (unreflected form)
//  REF_IN   0      1: each beat fed LSB first; 0: MSB first
//  REF_OUT  0      1: bit-reverse register before XOR_OUT
//  XOR_OUT  8'h00  XOR applied to final value, [CRC_W-1:0]
//  CNT_W    16     width of beat counter
// PORTS
//  clk        in   1       clock, all state changes on posedge
//  rst        in   1       reset, synchronous, active-high
//  in_valid   in   1       beat available
//  in_ready   out  1       engine accepts beat this cycle
//  in_data    in   DATA_W  beat payload
//  in_last    in   1       qualifies final beat of frame
//  in_abort   in   1       discard current partial frame
//  exp_crc    in   CRC_W   expected CRC, sampled with accepted in_last beat
//  out_valid  out  1       crc_out/crc_ok/beat_cnt valid
//  out_ready  in   1       consumer takes result
//  crc_out    out  CRC_W   final CRC (after REF_OUT, XOR_OUT)
//  crc_ok     out  1       crc_out == sampled exp_crc
//  beat_cnt   out  CNT_W   beats in finished frame, saturates at all-ones
// BEHAVIOUR
//  - States: ACCUM, HOLD. Reset: state=ACCUM, reg=INIT, beat count=0, out_valid=0,
//    crc_out=0, crc_ok=0, beat_cnt=0, exp latch=0.
//  - in_ready = (state==ACCUM). Beat accepted iff in_valid && in_ready.
//  - Per accepted beat: DATA_W serial steps in one cycle (unrolled): fb = reg[CRC_W-1]^bit;
//    reg = {reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). Bit order: in_data[DATA_W-1] first when
//    REF_IN=0, in_data[0] first when REF_IN=1. CRC_W=1: reg = fb ? POLY : 0.
//  - Beat counter increments per accepted beat, holds at 2^CNT_W-1 (no wrap).
//  - Accepted beat with in_last: next cycle state=HOLD, out_valid=1, crc_out = (REF_OUT ?
//    rev(reg') : reg') ^ XOR_OUT where reg' includes this beat; exp_crc latched; beat_cnt
//    includes this beat. Latency in_last accept -> out_valid: 1 cycle.
//  - HOLD: outputs stable, in_ready=0. On out_valid&&out_ready: next cycle state=ACCUM,
//    out_valid=0, reg=INIT, counter=0 (crc_out/crc_ok/beat_cnt keep last values).
//  - in_abort in ACCUM: reg=INIT, counter=0 next cycle; takes priority over a same-cycle
//    accepted beat (beat dropped, in_last ignored). in_abort ignored in HOLD.
//  - Zero-length frame impossible: a frame is >=1 beat.
//  - rst asserted mid-frame or in HOLD: reset values next cycle, partial frame lost.
//  - in_data/in_last ignored when not accepted; no combinational path in_valid->in_ready.
// TESTING
//  T1 CRC_W=8,POLY=07,INIT=00,REF=0,XOR=00,DATA_W=8: "123456789" 9 beats, exp=F4 ->
//     crc_out=F4, crc_ok=1, beat_cnt=9, out_valid 1 cycle after last accept.
//  T2 CRC-8/MAXIM POLY=31,REF_IN=REF_OUT=1: "123456789" -> A1; exp=A0 -> crc_ok=0.
//  T3 CRC_W=16,POLY=1021,INIT=FFFF: "123456789" -> 29B1; CRC_W=32,POLY=04C11DB7,
//     INIT/XOR=FFFFFFFF,REF=1 -> CBF43926; DATA_W=1 serial build gives identical results.
//  T4 Back-pressure: out_ready=0 for 5 cycles -> in_ready=0, outputs stable; release ->
//     next frame "123456789" again yields F4 (INIT restored).
//  T5 Abort: 4 beats, in_abort (with in_valid on same cycle), then full "123456789"
//     -> F4, beat_cnt=9; in_abort during HOLD has no effect.
//  T6 rst pulse mid-frame after 3 beats -> all outputs reset values next cycle; following
//     frame correct; random in_valid/out_ready gaps vs software model, 1000 frames.

Source files
------------

// File: rtl/crc_stream.sv
// Parametrised CRC engine with a valid/ready beat stream, per-frame result hold
// and compare against a caller-supplied expected CRC.
module crc_stream #(
    parameter int               CRC_W   = 8,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = 8'h07,
    parameter logic [CRC_W-1:0] INIT    = 8'h00,
    parameter bit               REF_IN  = 1'b0,
    parameter bit               REF_OUT = 1'b0,
    parameter logic [CRC_W-1:0] XOR_OUT = 8'h00,
    parameter int               CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_abort,
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    // Shifting left by one also covers CRC_W=1, where the register becomes fb ? POLY : 0.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             b;
        logic             fb;
        c = r;
        for (int i = 0; i < DATA_W; i++) begin
            b  = REF_IN ? d[i] : d[DATA_W-1-i];
            fb = c[CRC_W-1] ^ b;
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] v);
        return (REF_OUT ? bit_rev(v) : v) ^ XOR_OUT;
    endfunction

    logic [0:0]        state;
    logic [CRC_W-1:0]  acc_p0;
    logic [CNT_W-1:0]  beats_p0;
    logic [CRC_W-1:0]  acc_nxt;
    logic [CRC_W-1:0]  fin_nxt;
    logic [CNT_W-1:0]  beats_nxt;
    logic              vld_p1;
    logic [CRC_W-1:0]  crc_p1;
    logic              ok_p1;
    logic [CNT_W-1:0]  cnt_p1;

    assign in_ready  = (state == ACCUM);
    assign acc_nxt   = crc_step(acc_p0, in_data);
    assign fin_nxt   = finalize(acc_nxt);
    assign beats_nxt = (&beats_p0) ? beats_p0 : beats_p0 + 1'b1;

    // Stage p0: accumulate accepted beats; stage p1: latch finished-frame result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            acc_p0   <= INIT;
            beats_p0 <= '0;
            vld_p1   <= 1'b0;
            crc_p1   <= '0;
            ok_p1    <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_abort) begin
                        acc_p0   <= INIT;
                        beats_p0 <= '0;
                    end else if (in_valid) begin
                        acc_p0   <= acc_nxt;
                        beats_p0 <= beats_nxt;
                        if (in_last) begin
                            state  <= HOLD;
                            vld_p1 <= 1'b1;
                            crc_p1 <= fin_nxt;
                            ok_p1  <= (fin_nxt == exp_crc);
                            cnt_p1 <= beats_nxt;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state    <= ACCUM;
                        vld_p1   <= 1'b0;
                        acc_p0   <= INIT;
                        beats_p0 <= '0;
                    end
                end
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign crc_out   = crc_p1;
    assign crc_ok    = ok_p1;
    assign beat_cnt  = cnt_p1;

endmodule

// File: tb/tb_crc_stream.sv
// Directed and randomised checks of crc_stream across CRC-8, CRC-8/MAXIM, CRC-16,
// CRC-32, a saturating small counter and a one-bit-per-beat serial build.
module tb_crc_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_last, in_abort, out_ready;
    logic [7:0]  in_data;
    logic [7:0]  exp8, expm;
    logic [15:0] exp16;
    logic [31:0] exp32;

    logic        rdy_a, rdy_m, rdy_h, rdy_w, rdy_s;
    logic        ov_a, ov_m, ov_h, ov_w, ov_s;
    logic        ok_a, ok_m, ok_h, ok_w, ok_s;
    logic [7:0]  crc_a, crc_m, crc_s;
    logic [15:0] crc_h;
    logic [31:0] crc_w;
    logic [15:0] cnt_a, cnt_m, cnt_h, cnt_w;
    logic [2:0]  cnt_s;

    logic        s_valid, s_data, s_last, s_abort, s_oready, s_rdy, s_ov, s_ok;
    logic [7:0]  s_exp, s_crc;
    logic [15:0] s_cnt;

    crc_stream u_a (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .in_last(in_last), .in_abort(in_abort), .exp_crc(exp8),
        .out_valid(ov_a), .out_ready(out_ready), .crc_out(crc_a), .crc_ok(ok_a), .beat_cnt(cnt_a));

    crc_stream #(.POLY(8'h31), .REF_IN(1'b1), .REF_OUT(1'b1)) u_m (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data), .in_last(in_last),
        .in_abort(in_abort), .exp_crc(expm), .out_valid(ov_m), .out_ready(out_ready),
        .crc_out(crc_m), .crc_ok(ok_m), .beat_cnt(cnt_m));

    crc_stream #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)) u_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_h), .in_data(in_data),
        .in_last(in_last), .in_abort(in_abort), .exp_crc(exp16), .out_valid(ov_h),
        .out_ready(out_ready), .crc_out(crc_h), .crc_ok(ok_h), .beat_cnt(cnt_h));

    crc_stream #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REF_IN(1'b1),
                 .REF_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF)) u_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data),
        .in_last(in_last), .in_abort(in_abort), .exp_crc(exp32), .out_valid(ov_w),
        .out_ready(out_ready), .crc_out(crc_w), .crc_ok(ok_w), .beat_cnt(cnt_w));

    crc_stream #(.CNT_W(3)) u_s (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .in_data(in_data), .in_last(in_last), .in_abort(in_abort), .exp_crc(exp8),
        .out_valid(ov_s), .out_ready(out_ready), .crc_out(crc_s), .crc_ok(ok_s), .beat_cnt(cnt_s));

    crc_stream #(.DATA_W(1)) u_z (.clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_rdy),
        .in_data(s_data), .in_last(s_last), .in_abort(s_abort), .exp_crc(s_exp),
        .out_valid(s_ov), .out_ready(s_oready), .crc_out(s_crc), .crc_ok(s_ok), .beat_cnt(s_cnt));

    typedef struct {
        logic [95:0] d;
        int          len;
        logic [7:0]  e8, em;
        logic [15:0] e16;
        logic [31:0] e32;
        logic [7:0]  c8, cm;
        logic [15:0] c16;
        logic [31:0] c32;
        logic [3:0]  ok;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
                                              input logic [31:0] init, input logic [31:0] xo,
                                              input bit refl, input logic [95:0] d, input int len);
        logic [31:0] r, mask, rr;
        logic [7:0]  byt;
        logic        b, fb;
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        r = init;
        for (int k = 0; k < len; k++) begin
            byt = d[8*k +: 8];
            for (int i = 0; i < 8; i++) begin
                b  = refl ? byt[i] : byt[7-i];
                fb = r[w-1] ^ b;
                r  = ((r << 1) & mask) ^ (fb ? poly : 32'd0);
            end
        end
        rr = 32'd0;
        if (refl) begin
            for (int i = 0; i < w; i++) rr[i] = r[w-1-i];
        end else begin
            rr = r;
        end
        return (rr ^ xo) & mask;
    endfunction

    function automatic vec_t mk_vec(input logic [95:0] d, input int len, input bit flip);
        vec_t v;
        logic [31:0] t;
        v.d = d;
        v.len = len;
        t = crc_model(8, 32'h07, 32'h0, 32'h0, 1'b0, d, len);                         v.c8  = t[7:0];
        t = crc_model(8, 32'h31, 32'h0, 32'h0, 1'b1, d, len);                         v.cm  = t[7:0];
        t = crc_model(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, d, len);                   v.c16 = t[15:0];
        v.c32 = crc_model(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, d, len);
        v.e8  = flip ? v.c8  ^ 8'h01  : v.c8;
        v.em  = flip ? v.cm  ^ 8'h80  : v.cm;
        v.e16 = flip ? v.c16 ^ 16'h01 : v.c16;
        v.e32 = flip ? v.c32 ^ 32'h1  : v.c32;
        v.ok  = flip ? 4'h0 : 4'hF;
        return v;
    endfunction

    function automatic logic [95:0] digits();
        logic [95:0] d;
        d = '0;
        for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'h31 + 8'(k);
        return d;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready timeout", {63'd0, rdy_a}, 64'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid after release", {ov_a, ov_m, ov_h, ov_w, ov_s}, 5'h00);
        chk("in_ready after release", {rdy_a, rdy_m, rdy_h, rdy_w, rdy_s}, 5'h1F);
    endtask

    task automatic send_beats(input vec_t v, input int nb, input bit gaps, input bit last);
        for (int k = 0; k < nb; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    @(negedge clk);
                end
            end
            wait_ready();
            in_valid = 1'b1;
            in_data  = v.d[8*k +: 8];
            in_last  = last && (k == nb - 1);
            exp8  = in_last ? v.e8  : ~v.e8;
            expm  = in_last ? v.em  : ~v.em;
            exp16 = in_last ? v.e16 : ~v.e16;
            exp32 = in_last ? v.e32 : ~v.e32;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
        exp8 = 8'h5A; expm = 8'hA5; exp16 = 16'h1234; exp32 = 32'hDEADBEEF;
    endtask

    task automatic run_group(input vec_t v, input bit gaps, input int hold, input bit rel);
        send_beats(v, v.len, gaps, 1'b1);
        chk("out_valid 1 cycle after last", {ov_a, ov_m, ov_h, ov_w, ov_s}, 5'h1F);
        chk("crc8", crc_a, v.c8);
        chk("crc8_maxim", crc_m, v.cm);
        chk("crc16", crc_h, v.c16);
        chk("crc32", crc_w, v.c32);
        chk("crc8_cnt3", crc_s, v.c8);
        chk("crc_ok", {ok_a, ok_m, ok_h, ok_w, ok_s}, {v.ok, v.ok[3]});
        chk("beat_cnt", cnt_a, 64'(v.len));
        chk("beat_cnt_sat", cnt_s, (v.len > 7) ? 64'd7 : 64'(v.len));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_last  = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("hold in_ready", {rdy_a, rdy_m, rdy_h, rdy_w, rdy_s}, 5'h00);
            chk("hold outputs", {ov_a, crc_a, crc_w, cnt_a}, {1'b1, v.c8, v.c32, 16'(v.len)});
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (rel) release_out();
    endtask

    task automatic run_serial();
        logic [7:0] byt;
        int n;
        for (int k = 0; k < 9; k++) begin
            byt = 8'h31 + 8'(k);
            for (int b = 0; b < 8; b++) begin
                n = 0;
                while (!s_rdy && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) chk("serial in_ready timeout", {63'd0, s_rdy}, 64'd1);
                s_valid = 1'b1;
                s_data  = byt[7-b];
                s_last  = (k == 8) && (b == 7);
                s_exp   = s_last ? 8'hF4 : 8'h0B;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("serial out_valid", {63'd0, s_ov}, 64'd1);
        chk("serial crc8", s_crc, 64'hF4);
        chk("serial crc_ok", {63'd0, s_ok}, 64'd1);
        chk("serial beat_cnt", s_cnt, 64'd72);
        s_oready = 1'b1;
        @(negedge clk);
        s_oready = 1'b0;
        chk("serial release", {s_ov, s_rdy, s_crc}, {2'b01, 8'hF4});
    endtask

    vec_t tbl[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; exp8 = '0; expm = '0; exp16 = '0; exp32 = '0;
        s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; s_abort = 1'b0; s_oready = 1'b0; s_exp = '0;

        tbl[0] = mk_vec(digits(), 9, 1'b0);
        tbl[0].c8 = 8'hF4; tbl[0].cm = 8'hA1; tbl[0].c16 = 16'h29B1; tbl[0].c32 = 32'hCBF43926;
        tbl[0].e8 = 8'hF4; tbl[0].em = 8'hA1; tbl[0].e16 = 16'h29B1; tbl[0].e32 = 32'hCBF43926;
        tbl[0].ok = 4'hF;
        tbl[1] = tbl[0];
        tbl[1].e8 = 8'hF5; tbl[1].em = 8'hA0; tbl[1].e16 = 16'h29B0; tbl[1].e32 = 32'hCBF43927;
        tbl[1].ok = 4'h0;
        tbl[2] = mk_vec(96'h01, 1, 1'b0);
        tbl[2].c8 = 8'h07; tbl[2].cm = 8'h5E; tbl[2].e8 = 8'h07; tbl[2].em = 8'h5E;
        tbl[3] = mk_vec(96'h80, 1, 1'b0);
        tbl[3].c8 = 8'h89; tbl[3].cm = 8'h8C; tbl[3].e8 = 8'h88; tbl[3].em = 8'h8C;
        tbl[3].ok = 4'b0111;

        repeat (3) @(negedge clk);
        chk("reset out_valid", {ov_a, ov_m, ov_h, ov_w, ov_s, s_ov}, 6'h00);
        chk("reset in_ready", {rdy_a, rdy_m, rdy_h, rdy_w, rdy_s, s_rdy}, 6'h3F);
        chk("reset crc_out", {crc_a, crc_w, s_crc}, 48'h0);
        chk("reset crc_ok/beat_cnt", {ok_a, ok_w, cnt_a, s_cnt}, 34'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_group(tbl[i], 1'b0, 1, 1'b1);

        run_serial();

        // Back-pressure for 5 cycles, then INIT must be restored for the next frame.
        run_group(tbl[0], 1'b0, 5, 1'b1);
        run_group(tbl[0], 1'b0, 0, 1'b1);

        // Abort after 4 beats, with a same-cycle valid+last beat that must be dropped.
        send_beats(tbl[1], 4, 1'b0, 1'b0);
        in_valid = 1'b1; in_abort = 1'b1; in_last = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0; in_abort = 1'b0; in_last = 1'b0;
        chk("abort drops last beat", {ov_a, rdy_a}, 2'b01);
        run_group(tbl[0], 1'b0, 0, 1'b0);
        in_abort = 1'b1;
        @(negedge clk);
        in_abort = 1'b0;
        chk("abort in HOLD ignored", {ov_a, rdy_a, crc_a, cnt_a}, {2'b10, 8'hF4, 16'd9});
        release_out();

        run_group(tbl[3], 1'b0, 0, 1'b1);
        send_beats(tbl[0], 3, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h34; in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("mid-frame rst outputs", {ov_a, ok_a, ok_m, crc_a, crc_m, crc_w, cnt_a}, 64'h0);
        chk("mid-frame rst in_ready", {63'd0, rdy_a}, 64'd1);
        run_group(tbl[0], 1'b0, 0, 1'b1);

        for (int f = 0; f < 1000; f++) begin
            v = mk_vec({$urandom, $urandom, $urandom}, $urandom_range(1, 12), 1'($urandom));
            run_group(v, 1'b1, $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
